// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
//   - Major opcode constants consumed by the control decoder.
//   - NOP_INSTR: canonical bubble instruction (addi x0,x0,0).
//   - fetch_state_t: instruction-fetch FSM states.
//   - opcode_of / func3_of: field extractors for a 32-bit instruction.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [2:0] func3_of(input logic [31:0] instr);
    return instr[14:12];
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 drop the held instruction (highest priority)
//   load                  capture load_instr/load_pc as a valid instruction
//   consume               decoder took the instruction and nothing refills it
//   load_instr, load_pc   data to capture on load
//   valid, instr, pc      registered IF/ID contents
// A flushed or consumed slot is refilled with NOP_INSTR so the decoder always
// sees a harmless encoding; pc keeps its last value in that case.
module if_id_reg #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  logic            consume,
  input  logic [31:0]     load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (consume) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID register, feeding the control decoder.
// Issues one outstanding request at a time to instruction memory, captures the
// response with its PC, and absorbs a decode stall with a one-entry skid buffer.
// Redirect flushes IF/ID and any in-flight response, then refetches.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_ready       fetch request handshake
//   imem_rvalid/imem_rdata              fetch response
//   stall_i                             decode cannot accept this cycle
//   redirect_i/redirect_pc              taken branch/jump target
//   id_valid/id_instr/id_pc             IF/ID register contents
//   id_opcode/id_func3                  decoder fields of id_instr
//   perf_fetched/perf_bubbles           only when IF_PERF_CNT_EN is defined
//
// Build option: define IF_PERF_CNT_EN to add the two wrapping 32-bit
// performance counters (IF/ID loads, cycles with id_valid=0).
//
// state   | meaning
// FETCH   | request driven at pc, waiting for imem_ready
// WAIT    | request accepted, waiting for the response
// HOLD    | response parked in the skid buffer while decode stalls
// DISCARD | response still owed by memory but belongs to a flushed path
module if_fetch_stage #(
  parameter int unsigned XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode,
`ifdef IF_PERF_CNT_EN
  output logic [2:0]      id_func3,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_bubbles
`else
  output logic [2:0]      id_func3
`endif
);

  import riscv_pkg::*;

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, req_pc;
  logic [XLEN-1:0] redirect_tgt;

  logic            skid_valid;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc;

  logic            req_accept;
  logic            id_free;
  logic            id_load;
  logic            load_from_skid;
  logic            skid_store;
  logic            skid_clear;
  logic            id_consume;
  logic [31:0]     load_instr;
  logic [XLEN-1:0] load_pc;

  assign req_accept   = (state == FETCH) && imem_ready;
  assign id_free      = !id_valid || !stall_i;
  assign redirect_tgt = redirect_pc & ~XLEN'(3);

  // Gated by rst_n so no request escapes while reset is held.
  assign imem_req  = rst_n && (state == FETCH);
  assign imem_addr = pc;

  always_comb begin
    state_nxt      = state;
    id_load        = 1'b0;
    load_from_skid = 1'b0;
    skid_store     = 1'b0;
    skid_clear     = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ready) state_nxt = redirect_i ? DISCARD : WAIT;
      end
      WAIT: begin
        if (redirect_i) begin
          state_nxt = imem_rvalid ? FETCH : DISCARD;
        end else if (imem_rvalid) begin
          if (id_free) begin
            id_load   = 1'b1;
            state_nxt = FETCH;
          end else begin
            skid_store = 1'b1;
            state_nxt  = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_i) begin
          skid_clear = 1'b1;
          state_nxt  = FETCH;
        end else if (!stall_i && skid_valid) begin
          id_load        = 1'b1;
          load_from_skid = 1'b1;
          skid_clear     = 1'b1;
          state_nxt      = FETCH;
        end
      end
      DISCARD: begin
        // A redirect here still owes the old response, so keep waiting for it.
        if (!redirect_i && imem_rvalid) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  assign id_consume = !stall_i && id_valid && !id_load;
  assign load_instr = load_from_skid ? skid_instr : imem_rdata;
  assign load_pc    = load_from_skid ? skid_pc : req_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (req_accept) req_pc <= pc;
      if (redirect_i)      pc <= redirect_tgt;
      else if (req_accept) pc <= pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= '0;
    end else if (skid_clear) begin
      skid_valid <= 1'b0;
    end else if (skid_store && !redirect_i) begin
      skid_valid <= 1'b1;
      skid_instr <= imem_rdata;
      skid_pc    <= req_pc;
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_i),
    .load       (id_load),
    .consume    (id_consume),
    .load_instr (load_instr),
    .load_pc    (load_pc),
    .valid      (id_valid),
    .instr      (id_instr),
    .pc         (id_pc)
  );

  assign id_opcode = opcode_of(id_instr);
  assign id_func3  = func3_of(id_instr);

`ifdef IF_PERF_CNT_EN
  // A load suppressed by redirect is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (id_load && !redirect_i) perf_fetched <= perf_fetched + 32'd1;
      if (!id_valid)              perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_func3;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_opcode(id_opcode),
`ifdef IF_PERF_CNT_EN
    .id_func3(id_func3), .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`else
    .id_func3(id_func3)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: tracks whether a request is outstanding, whether
  // its answer is to be thrown away, and whether a response is parked.
  logic [31:0] m_pc, m_reqpc, m_idi, m_idpc, m_bi, m_bpc;
  bit          m_out, m_drop, m_buf, m_idv;
  int unsigned m_fetched, m_bub;
  bit          fetching, loaded;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_reqpc = 32'h0; m_out = 0; m_drop = 0; m_buf = 0;
      m_idv = 0; m_idi = NOP; m_idpc = 32'h0; m_bi = NOP; m_bpc = 32'h0;
      m_fetched = 0; m_bub = 0;
    end else begin
      fetching = !m_out && !m_buf;
      loaded = 0;
      if (!m_idv) m_bub++;
      if (redirect_i) begin
        if (fetching && imem_ready) begin
          m_out = 1; m_drop = 1;
        end else if (m_out && !m_drop) begin
          if (imem_rvalid) m_out = 0;
          else m_drop = 1;
        end
        m_buf = 0;
        m_pc = redirect_pc & ~32'd3;
        m_idv = 0; m_idi = NOP;
      end else begin
        if (fetching && imem_ready) begin
          m_reqpc = m_pc; m_pc = m_pc + 32'd4; m_out = 1; m_drop = 0;
        end else if (m_out && imem_rvalid) begin
          m_out = 0;
          if (m_drop) m_drop = 0;
          else if (!m_idv || !stall_i) begin
            m_idv = 1; m_idi = imem_rdata; m_idpc = m_reqpc; loaded = 1;
          end else begin
            m_buf = 1; m_bi = imem_rdata; m_bpc = m_reqpc;
          end
        end else if (m_buf && !stall_i) begin
          m_idv = 1; m_idi = m_bi; m_idpc = m_bpc; m_buf = 0; loaded = 1;
        end
        if (!loaded && !stall_i && m_idv) begin
          m_idv = 0; m_idi = NOP;
        end
        if (loaded) m_fetched++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("req", 32'(imem_req), 32'(rst_n && !m_out && !m_buf));
    chk("addr", imem_addr, m_pc);
    chk("id_valid", 32'(id_valid), 32'(m_idv));
    chk("id_instr", id_instr, m_idi);
    chk("id_pc", id_pc, m_idpc);
    chk("opcode", 32'(id_opcode), 32'(m_idi[6:0]));
    chk("func3", 32'(id_func3), 32'(m_idi[14:12]));
`ifdef IF_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_bubbles", perf_bubbles, m_bub);
`endif
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_idv", 32'(id_valid), 32'h0);
    chk("rst_instr", id_instr, NOP);

    // Basic fetch: accept at pc 0, respond next cycle.
    rst_n = 1; imem_ready = 1;
    step();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h0050_0093;
    step();
    imem_rvalid = 0;
    chk("s1_idv", 32'(id_valid), 32'h1);
    chk("s1_idpc", id_pc, 32'h0);
    chk("s1_opc", 32'(id_opcode), 32'h13);
    chk("s1_f3", 32'(id_func3), 32'h0);
    chk("s1_addr", imem_addr, 32'h4);

    // Response arrives during a stall: parked, then released.
    stall_i = 1; imem_ready = 1;
    step();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h0000_A103;
    step();
    imem_rvalid = 0;
    step();
    chk("s2_hold_req", 32'(imem_req), 32'h0);
    chk("s2_hold_instr", id_instr, 32'h0050_0093);
    stall_i = 0;
    step();
    chk("s2_instr", id_instr, 32'h0000_A103);
    chk("s2_pc", id_pc, 32'h4);
    chk("s2_f3", 32'(id_func3), 32'h2);

    // Redirect while waiting; the late response must be dropped.
    imem_ready = 1;
    step();
    imem_ready = 0; redirect_i = 1; redirect_pc = 32'h100;
    step();
    redirect_i = 0;
    step(2);
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 0;
    chk("s3_idv", 32'(id_valid), 32'h0);
    chk("s3_addr", imem_addr, 32'h100);
    chk("s3_req", 32'(imem_req), 32'h1);

    // Redirect coincident with the response, misaligned target.
    imem_ready = 1;
    step();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h1234_5678;
    redirect_i = 1; redirect_pc = 32'h203;
    step();
    imem_rvalid = 0; redirect_i = 0;
    chk("s4_addr", imem_addr, 32'h200);
    chk("s4_idv", 32'(id_valid), 32'h0);

    // PC wrap at the top of the address space, then a held stall.
    redirect_i = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_i = 0; imem_ready = 1;
    step();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0063;
    step();
    imem_rvalid = 0;
    chk("s5_addr", imem_addr, 32'h0);
    chk("s5_idpc", id_pc, 32'hFFFF_FFFC);
    chk("s5_opc", 32'(id_opcode), 32'h63);
    stall_i = 1;
    step(2);
    chk("s5_stall_v", 32'(id_valid), 32'h1);
    chk("s5_stall_i", id_instr, 32'h0000_0063);

    // Reach the parked state, then reset mid-cycle.
    imem_ready = 1;
    step();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h0020_81B3;
    step();
    imem_rvalid = 0;
    chk("s6_hold_req", 32'(imem_req), 32'h0);
    #2 rst_n = 0;
    #1;
    chk("s6_rst_idv", 32'(id_valid), 32'h0);
    chk("s6_rst_addr", imem_addr, 32'h0);
    chk("s6_rst_req", 32'(imem_req), 32'h0);
    chk("s6_rst_instr", id_instr, NOP);
`ifdef IF_PERF_CNT_EN
    chk("s6_rst_pf", perf_fetched, 32'h0);
    chk("s6_rst_pb", perf_bubbles, 32'h0);
`endif
    step(2);
    stall_i = 0; rst_n = 1;
    // Stray response while fetching after reset: ignored.
    imem_rvalid = 1; imem_rdata = 32'h0000_006F;
    step();
    imem_rvalid = 0;
    chk("s7_idv", 32'(id_valid), 32'h0);
    chk("s7_addr", imem_addr, 32'h0);
    chk("s7_req", 32'(imem_req), 32'h1);
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
